// File: rtl/wolf_pkg.sv
// Shared definitions for the wall collision checker.
// Holds the move codes, FSM state encoding, map geometry constants and the
// step decoder used by the CALC stage.
package wolf_pkg;

  localparam logic [1:0] MOVE_NONE  = 2'd0;
  localparam logic [1:0] MOVE_RIGHT = 2'd1;
  localparam logic [1:0] MOVE_LEFT  = 2'd2;
  localparam logic [1:0] MOVE_DOWN  = 2'd1;
  localparam logic [1:0] MOVE_UP    = 2'd2;

  localparam int GRID_COLS = 8;
  localparam int GRID_ROWS = 8;
  localparam int CELL_BITS = 2;
  localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;

  localparam logic [1:0] WALL_EMPTY = 2'd0;

  // Coordinate width for the scan datapath; wide enough for x'+w and cx+C.
  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Decode a move code into a signed one-pixel delta; code 3 acts as none.
  function automatic logic signed [12:0] step_of(input logic [1:0] code,
                                                 input logic [1:0] pos_code,
                                                 input logic [1:0] neg_code);
    if (code == pos_code)      step_of = 13'sd1;
    else if (code == neg_code) step_of = -13'sd1;
    else                       step_of = 13'sd0;
  endfunction

endpackage

// File: rtl/cell_overlap.sv
// Combinational rectangle overlap test: stepped player box versus one
// map cell of edge CELL_SIZE. Edges are half-open, so touching boxes do
// not overlap.
module cell_overlap
  import wolf_pkg::*;
#(
  parameter int CELL_SIZE = 60
) (
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  input  logic [COORD_W-1:0] box_w,
  input  logic [COORD_W-1:0] box_h,
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  output logic               overlap
);

  localparam logic [COORD_W-1:0] CSZ = COORD_W'(CELL_SIZE);

  assign overlap = (box_x < cell_x + CSZ) && (cell_x < box_x + box_w) &&
                   (box_y < cell_y + CSZ) && (cell_y < box_y + box_h);

endmodule

// File: rtl/wall_collision_checker.sv
// Responder for the player-move start/done handshake: steps the captured
// box by one pixel, rejects screen under/overflow, then scans the 8x8 map
// one cell per cycle looking for a wall under the stepped box.
// Optional feature macro: WALL_CHECK_BOUNDS_EN also rejects moves that leave
// the map area (otherwise the area outside the map counts as floor).
//
// state | meaning
// IDLE  | waiting for start; captures request on start
// CALC  | compute stepped box, bounds and no-move shortcuts
// SCAN  | test cell idx per cycle; early exit on a wall hit
// DONE  | done=1 with verdict; wait for start to drop
module wall_collision_checker
  import wolf_pkg::*;
#(
  parameter int GRID_X0   = 0,
  parameter int GRID_Y0   = 0,
  parameter int CELL_SIZE = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   l_r,
  input  logic [1:0]   u_d,
  input  logic [9:0]   x_pos,
  input  logic [9:0]   y_pos,
  input  logic [9:0]   width,
  input  logic [9:0]   height,
  input  logic [0:127] grid_color,
  output logic         done,
  output logic         move_is_valid,
  output logic         busy
);

  localparam logic signed [12:0] SCREEN_MAX = 13'sd1023;
`ifdef WALL_CHECK_BOUNDS_EN
  localparam logic signed [12:0] MAP_X0 = 13'(GRID_X0);
  localparam logic signed [12:0] MAP_Y0 = 13'(GRID_Y0);
  localparam logic signed [12:0] MAP_X1 = 13'(GRID_X0 + GRID_COLS * CELL_SIZE);
  localparam logic signed [12:0] MAP_Y1 = 13'(GRID_Y0 + GRID_ROWS * CELL_SIZE);
`endif

  state_t state, state_nxt;

  logic [9:0] x_q, y_q, w_q, h_q;
  logic [1:0] lr_q, ud_q;
  logic [5:0] idx;
  logic       valid_q;

  logic              capture, verdict_load, verdict_val, idx_clr, idx_inc;
  logic signed [12:0] dx, dy, sx, sy, x_end, y_end;
  logic [9:0]        w_eff, h_eff;
  logic              out_of_range, no_move;
  logic [COORD_W-1:0] cell_x, cell_y;
  logic [1:0]        code;
  logic              overlap, hit;

  // Stepped box derived from the captured request; held stable through SCAN.
  assign dx    = step_of(lr_q, MOVE_RIGHT, MOVE_LEFT);
  assign dy    = step_of(ud_q, MOVE_DOWN, MOVE_UP);
  assign w_eff = (w_q == 10'd0) ? 10'd1 : w_q;
  assign h_eff = (h_q == 10'd0) ? 10'd1 : h_q;
  assign sx    = $signed({3'b000, x_q}) + dx;
  assign sy    = $signed({3'b000, y_q}) + dy;
  assign x_end = sx + $signed({3'b000, w_eff});
  assign y_end = sy + $signed({3'b000, h_eff});

  // Screen limits, plus the map edges when bounds checking is built in.
  always_comb begin
    out_of_range = (sx < 13'sd0) || (sy < 13'sd0) ||
                   (x_end > SCREEN_MAX) || (y_end > SCREEN_MAX);
`ifdef WALL_CHECK_BOUNDS_EN
    if ((sx < MAP_X0) || (sy < MAP_Y0) || (x_end > MAP_X1) || (y_end > MAP_Y1))
      out_of_range = 1'b1;
`endif
  end

  assign no_move = (dx == 13'sd0) && (dy == 13'sd0);

  // Cell under test: column idx[2:0], row idx[5:3]; map is read live.
  assign cell_x = COORD_W'(GRID_X0) + COORD_W'(idx[2:0]) * COORD_W'(CELL_SIZE);
  assign cell_y = COORD_W'(GRID_Y0) + COORD_W'(idx[5:3]) * COORD_W'(CELL_SIZE);
  assign code   = grid_color[{idx, 1'b0} +: CELL_BITS];

  cell_overlap #(.CELL_SIZE(CELL_SIZE)) u_cell_overlap (
    .box_x   ({3'b000, sx[12:0]}),
    .box_y   ({3'b000, sy[12:0]}),
    .box_w   ({6'b000000, w_eff}),
    .box_h   ({6'b000000, h_eff}),
    .cell_x  (cell_x),
    .cell_y  (cell_y),
    .overlap (overlap)
  );

  assign hit = overlap && (code != WALL_EMPTY);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    verdict_load = 1'b0;
    verdict_val  = 1'b0;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (out_of_range) begin
          verdict_load = 1'b1;
          verdict_val  = 1'b0;
          state_nxt    = ST_DONE;
        end else if (no_move) begin
          verdict_load = 1'b1;
          verdict_val  = 1'b1;
          state_nxt    = ST_DONE;
        end else begin
          idx_clr   = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else if (hit) begin
          verdict_load = 1'b1;
          verdict_val  = 1'b0;
          state_nxt    = ST_DONE;
        end else if (idx == 6'(NUM_CELLS - 1)) begin
          verdict_load = 1'b1;
          verdict_val  = 1'b1;
          state_nxt    = ST_DONE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (!start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, scan index and verdict register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      lr_q    <= MOVE_NONE;
      ud_q    <= MOVE_NONE;
      idx     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (capture) begin
        x_q     <= x_pos;
        y_q     <= y_pos;
        w_q     <= width;
        h_q     <= height;
        lr_q    <= l_r;
        ud_q    <= u_d;
        valid_q <= 1'b0;
      end
      if (verdict_load) valid_q <= verdict_val;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 6'd1;
    end
  end

  assign done          = (state == ST_DONE);
  assign busy          = (state == ST_CALC) || (state == ST_SCAN);
  assign move_is_valid = valid_q;

endmodule

// File: tb/tb_wall_collision_checker.sv
// Self-checking bench for wall_collision_checker: directed scenarios and
// randomized requests against a behavioural model of the move rules.
// Honors WALL_CHECK_BOUNDS_EN the same way the design does.
module tb_wall_collision_checker;

  localparam int GX0 = 0;
  localparam int GY0 = 0;
  localparam int CSZ = 60;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   l_r = '0;
  logic [1:0]   u_d = '0;
  logic [9:0]   x_pos = '0;
  logic [9:0]   y_pos = '0;
  logic [9:0]   width = '0;
  logic [9:0]   height = '0;
  logic [0:127] grid_color = '0;
  logic         done;
  logic         move_is_valid;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  wall_collision_checker #(.GRID_X0(GX0), .GRID_Y0(GY0), .CELL_SIZE(CSZ)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .l_r           (l_r),
    .u_d           (u_d),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .width         (width),
    .height        (height),
    .grid_color    (grid_color),
    .done          (done),
    .move_is_valid (move_is_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: verdict and handshake latency straight from the move rules.
  function automatic void model(input int x, input int y, input int w, input int h,
                                input logic [1:0] lr, input logic [1:0] ud,
                                input logic [0:127] g, output bit valid, output int lat);
    int we, he, dx, dy, nx, ny, cx, cy;
    logic [1:0] c;
    we = (w == 0) ? 1 : w;
    he = (h == 0) ? 1 : h;
    dx = (lr == 2'd1) ? 1 : (lr == 2'd2) ? -1 : 0;
    dy = (ud == 2'd1) ? 1 : (ud == 2'd2) ? -1 : 0;
    nx = x + dx;
    ny = y + dy;
    lat = 2;
    valid = 1'b0;
    if (nx < 0 || ny < 0 || nx + we > 1023 || ny + he > 1023) return;
`ifdef WALL_CHECK_BOUNDS_EN
    if (nx < GX0 || ny < GY0 || nx + we > GX0 + 8 * CSZ || ny + he > GY0 + 8 * CSZ) return;
`endif
    valid = 1'b1;
    if (dx == 0 && dy == 0) return;
    for (int k = 0; k < 64; k++) begin
      cx = GX0 + (k % 8) * CSZ;
      cy = GY0 + (k / 8) * CSZ;
      c  = g[2*k +: 2];
      if (c != 2'd0 && nx < cx + CSZ && cx < nx + we && ny < cy + CSZ && cy < ny + he) begin
        valid = 1'b0;
        lat = k + 3;
        return;
      end
    end
    lat = 66;
  endfunction

  // One full 4-phase request with latency, verdict and release checks.
  task automatic run_req(input string tag, input int x, input int y, input int w, input int h,
                         input logic [1:0] lr, input logic [1:0] ud);
    bit ev;
    int el, cyc;
    bit seen;
    model(x, y, w, h, lr, ud, grid_color, ev, el);
    x_pos = 10'(x); y_pos = 10'(y); width = 10'(w); height = 10'(h);
    l_r = lr; u_d = ud;
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        x_pos = 10'($urandom); y_pos = 10'($urandom);
        width = 10'($urandom); height = 10'($urandom);
        l_r = 2'($urandom); u_d = 2'($urandom);
      end
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(el));
    check({tag, "_valid"}, 32'(move_is_valid), 32'(ev));
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_valid_hold"}, 32'(move_is_valid), 32'(ev));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [0:127] g;
    bit seen_done;
    int rx, ry;

    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(move_is_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Empty map, full scan
    grid_color = '0;
    run_req("empty_right", 310, 200, 20, 20, 2'd1, 2'd0);

    // Wall at cell 9
    g = '0;
    g[18 +: 2] = 2'd1;
    grid_color = g;
    run_req("cell9_left", 120, 60, 20, 20, 2'd2, 2'd0);
    run_req("cell9_right", 120, 60, 20, 20, 2'd1, 2'd0);

    // No-move shortcuts
    run_req("no_move", 200, 300, 10, 10, 2'd0, 2'd0);
    run_req("code3_move", 200, 300, 10, 10, 2'd3, 2'd3);

    // Screen and map edges
    grid_color = '0;
    run_req("x0_left", 0, 100, 20, 20, 2'd2, 2'd0);
    run_req("y0_up", 100, 0, 20, 20, 2'd0, 2'd2);
    run_req("map_edge", 460, 200, 20, 20, 2'd1, 2'd0);
    run_req("screen_edge", 1003, 100, 20, 20, 2'd1, 2'd0);
    run_req("zero_size", 300, 300, 0, 0, 2'd0, 2'd1);

    // Hits at the first and last cells
    g = '0;
    g[0 +: 2] = 2'd2;
    g[126 +: 2] = 2'd3;
    grid_color = g;
    run_req("hit_cell0", 10, 10, 5, 5, 2'd1, 2'd0);
    run_req("hit_cell63", 440, 440, 10, 10, 2'd0, 2'd1);

    // Abort mid-scan
    grid_color = '0;
    x_pos = 10'd310; y_pos = 10'd200; width = 10'd20; height = 10'd20;
    l_r = 2'd1; u_d = 2'd0;
    start = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_done", 32'(seen_done), 32'd0);
    check("abort_valid", 32'(move_is_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    run_req("after_abort", 310, 200, 20, 20, 2'd1, 2'd0);

    // Asynchronous reset mid-scan
    start = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(move_is_valid), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_req("after_rst", 310, 200, 20, 20, 2'd1, 2'd0);

    // Randomized requests over random maps
    for (int n = 0; n < 40; n++) begin
      g = '0;
      for (int k = 0; k < 64; k++)
        if ($urandom_range(0, 9) == 0) g[2*k +: 2] = 2'($urandom_range(1, 3));
      grid_color = g;
      rx = $urandom_range(0, 540);
      ry = $urandom_range(0, 540);
      if ($urandom_range(0, 7) == 0) rx = $urandom_range(990, 1023);
      if ($urandom_range(0, 7) == 0) ry = $urandom_range(0, 2);
      run_req("random", rx, ry, $urandom_range(0, 80), $urandom_range(0, 80),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
